// File: rtl/pwm_sample_feeder_if.sv
// Sample handshake and PWM-side outputs of pwm_sample_feeder.
// The producer/bench uses master; the feeder uses slave.
interface pwm_sample_feeder_if #(
    parameter int DEPTH = 8
);
    logic [15:0]            in_data;
    logic                   in_valid;
    logic                   in_ready;
    logic [11:0]            sample;
    logic                   frame;
    logic                   underrun;
    logic [$clog2(DEPTH):0] level;

    modport master (
        output in_data, in_valid,
        input  in_ready, sample, frame, underrun, level
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, sample, frame, underrun, level
    );
endinterface

// File: rtl/pwm_sample_feeder.sv
// Buffers signed 16-bit samples and releases one 12-bit unsigned code per PWM frame.
// Optional PWM_FEEDER_NOISE_SHAPE_EN swaps rounding for first-order error feedback.
module pwm_sample_feeder #(
    parameter int PERIOD = 4095,
    parameter int DEPTH  = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    pwm_sample_feeder_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(PERIOD);

    logic [CW-1:0] fcnt_q, fcnt_d;
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [LW-1:0] level_q, level_d;
    logic [11:0]   sample_q, sample_d;
    logic          frame_q, frame_d;
    logic          underrun_q, underrun_d;
    logic [15:0]   mem [DEPTH];

    logic          full, empty, ready, frame_evt, push, pop;
    logic [15:0]   head;
    logic [16:0]   u, v;
    logic [11:0]   conv;

`ifdef PWM_FEEDER_NOISE_SHAPE_EN
    logic [3:0]    err_q, err_d;
`else
    logic          unused_low_bits;
    assign unused_low_bits = ^v[3:0];
`endif

    always_comb begin
        full      = (level_q == LW'(DEPTH));
        empty     = (level_q == '0);
        ready     = rst_n && !full;
        frame_evt = (fcnt_q == CW'(PERIOD - 1));
        push      = bus.in_valid && ready;
        // No bypass: a sample pushed on a frame edge waits for the next frame.
        pop       = frame_evt && !empty;
        head      = mem[rptr_q];
        u         = {1'b0, ~head[15], head[14:0]};
`ifdef PWM_FEEDER_NOISE_SHAPE_EN
        v         = u + {13'd0, err_q};
`else
        v         = u + 17'd8;
`endif
        conv      = v[16] ? 12'hFFF : v[15:4];
    end

    always_comb begin
        fcnt_d     = frame_evt ? '0 : fcnt_q + CW'(1);
        wptr_d     = push ? wptr_q + AW'(1) : wptr_q;
        rptr_d     = pop  ? rptr_q + AW'(1) : rptr_q;
        level_d    = level_q + LW'(push) - LW'(pop);
        sample_d   = pop ? conv : sample_q;
        frame_d    = frame_evt;
        underrun_d = frame_evt && empty;
`ifdef PWM_FEEDER_NOISE_SHAPE_EN
        err_d      = err_q;
        if (pop) begin
            err_d = v[16] ? 4'd0 : v[3:0];
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fcnt_q     <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            level_q    <= '0;
            sample_q   <= 12'd2048;
            frame_q    <= 1'b0;
            underrun_q <= 1'b0;
`ifdef PWM_FEEDER_NOISE_SHAPE_EN
            err_q      <= 4'd0;
`endif
        end else begin
            fcnt_q     <= fcnt_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            level_q    <= level_d;
            sample_q   <= sample_d;
            frame_q    <= frame_d;
            underrun_q <= underrun_d;
`ifdef PWM_FEEDER_NOISE_SHAPE_EN
            err_q      <= err_d;
`endif
        end
    end

    // Storage carries no reset; occupancy and pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr_q] <= bus.in_data;
        end
    end

    assign bus.in_ready = ready;
    assign bus.sample   = sample_q;
    assign bus.frame    = frame_q;
    assign bus.underrun = underrun_q;
    assign bus.level    = level_q;
endmodule

// File: doc/pwm_sample_feeder.md
# pwm_sample_feeder

Rate-adapting sample source sitting directly upstream of `pwm_audio`. It accepts signed 16-bit mixed audio samples over a valid/ready handshake and buffers them in a small FIFO. It converts each sample to the 12-bit unsigned code `pwm_audio` consumes, and releases exactly one new sample per PWM frame. The result is that `pwm_audio` sees a sample change only at frame boundaries, and upstream producers can run bursty.

## Interface
- `PERIOD`, 4095 — PWM frame length in clocks; must match `pwm_audio` period; ≥ 4.
- `DEPTH`, 8 — FIFO entries; power of two, 2..64.
- `clk`  in  1 — clock.
- `rst_n`  in  1 — reset, synchronous, active-low.
- `in_data`  in  16 — signed two's-complement input sample.
- `in_valid`  in  1 — `in_data` valid.
- `in_ready`  out  1 — FIFO can accept; push = `in_valid && in_ready`.
- `sample`  out  12 — unsigned code to `pwm_audio.sample`; 2048 = silence.
- `frame`  out  1 — one-cycle pulse, high in the cycle `sample` takes its new value.
- `underrun`  out  1 — one-cycle pulse coincident with `frame` when FIFO was empty.
- `level`  out  $clog2(DEPTH)+1 — current FIFO occupancy.

## Operation
- Frame counter `fcnt` runs 0..PERIOD-1 and wraps. A frame event occurs on the edge where `fcnt == PERIOD-1`.
- On a frame event:
  - If FIFO is not empty: pop the head, convert it, and register the result into `sample`. `frame` = 1.
  - If FIFO is empty: `sample` holds its last value. `frame` = 1 and `underrun` = 1.
- Push: `in_ready = !full` (combinational from occupancy). `in_ready` is 0 while `rst_n` is low. No bypass: a push on the same edge as a frame event into an empty FIFO is not popped that frame, so `underrun` fires.
- Simultaneous push and pop in the same edge: `level` is unchanged and both operations take effect. When the FIFO is full, no push is possible (`in_ready` = 0), even on a pop edge.
- Conversion (on pop):
  - `u = {~in_data[15], in_data[14:0]}` (17-bit headroom).
  - Base (no macro): `v = u + 8`, saturating at 65535. `sample = v[15:4]`.
  - A saturated result is always 4095. Negative full scale 0x8000 gives 0.
- FIFO storage is a circular buffer with wrap-around read/write pointers of width $clog2(DEPTH). Full and empty are derived from `level`.

## Timing
- Reset values: `sample` = 2048, `frame` = 0, `underrun` = 0, `level` = 0, `fcnt` = 0, FIFO pointers 0, noise-shaping residual 0.
- The first frame event is on the PERIOD-th rising edge with `rst_n` high. Subsequent frame events occur every PERIOD clocks exactly.
- Latency: a pushed sample appears on `sample` at the first frame event strictly after its push edge, plus any queue ahead of it.
- `level` updates on the push/pop edge. `in_ready` reflects the new `level` in the following cycle.
- Reset asserted mid-operation: on the next edge the FIFO is flushed, `sample` returns to 2048, and `fcnt` restarts at 0. Queued samples are discarded without `underrun`.
- `in_data` is sampled only on push edges. It may change freely otherwise.

## Configuration
- `PWM_FEEDER_NOISE_SHAPE_EN` defined: first-order error-feedback noise shaping replaces rounding.
  - Keep a 4-bit residual `err`.
  - On each pop, `v = u + err`, saturating at 65535. `sample = v[15:4]` and `err <= v[3:0]`.
  - On saturation `err <= 0`.
  - `err` is untouched on underrun.
- Undefined: round-half-up as above. No residual register is synthesized.

## Test plan
- Reset, bench with `PERIOD`=16 and `DEPTH`=4 → `sample`=2048, `frame`=0, `level`=0. `in_ready`=1 in the first cycle after release. First `frame` arrives on the 16th active edge.
- Conversion (macro off): pushes 0x0000, 0x7FFF, 0x8000, 0x0007, 0x0008 → successive frames give `sample` 2048, 4095, 0, 2048, 2049.
- Full: push 4 with no frame in between → `level`=4 and `in_ready`=0. A fifth `in_valid` is held off. After the next frame, `level`=3 and `in_ready`=1, then the fifth is accepted.
- Underrun: empty FIFO at a frame event, and separately a push on the same edge as the frame → `underrun`=1 with `frame`, and `sample` unchanged. The pushed sample emerges one frame later.
- Noise shaping (macro on): constant input 0x0004 → `sample` repeats 2048, 2048, 2048, 2049. With the macro off, the same input gives 2048 constantly.
- Mid-run reset: 3 entries queued, `rst_n` low for one cycle → `level`=0 and `sample`=2048. The next `frame` arrives PERIOD edges after release, with `underrun`=1.
